// File: rtl/cfg_spi_loader_if.sv
// SPI pin group and register-bank write port of cfg_spi_loader.
// spi_miso exists only when CFG_SPI_READBACK_EN is defined.
interface cfg_spi_loader_if #(
  parameter int unsigned AW = 2,
  parameter int unsigned DW = 16
) ();
  logic          spi_sclk;
  logic          spi_cs_n;
  logic          spi_mosi;
`ifdef CFG_SPI_READBACK_EN
  logic          spi_miso;
`endif
  logic          reg_wr;
  logic [AW-1:0] reg_adr;
  logic [DW-1:0] reg_dat;

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
`ifdef CFG_SPI_READBACK_EN
    output spi_miso,
`endif
    output reg_wr, reg_adr, reg_dat
  );

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
`ifdef CFG_SPI_READBACK_EN
    input  spi_miso,
`endif
    input  reg_wr, reg_adr, reg_dat
  );
endinterface

// File: rtl/cfg_spi_loader.sv
// SPI mode-0 slave, oversampled in clk_i, turning cmd+data frames into register writes.
// Optional readback (cmd 2'b11) is enabled by defining CFG_SPI_READBACK_EN.
module cfg_spi_loader #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AW          = 2,
  parameter int unsigned DW          = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  cfg_spi_loader_if.slave     bus_if,
`ifdef CFG_SPI_READBACK_EN
  input  logic [DW-1:0]       reg0_i,
  input  logic [DW-1:0]       reg1_i,
  input  logic [DW-1:0]       reg2_i,
  input  logic [DW-1:0]       reg3_i,
`endif
  output logic                busy_o,
  output logic                frame_err_o,
  output logic [7:0]          frame_cnt_o
);

  localparam int unsigned FW = 8 + DW;
  localparam int unsigned CW = $clog2(FW + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT,
    ST_WAIT
  } state_e;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q;
  logic                   sclk_s, cs_s, mosi_s, rise;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus_if.spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0],   bus_if.spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus_if.spi_mosi};
      sclk_dly_q  <= sclk_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_dly_q;

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]   sr_q, sr_d, sr_next;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic            err_q, err_d;
  logic            last_bit;

  assign sr_next  = {sr_q[FW-2:0], mosi_s};
  assign last_bit = (bit_cnt_q == CW'(FW - 1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (!cs_s) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // A final rise strobe wins over a simultaneous cs_n release.
        if (rise) begin
          sr_d      = sr_next;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) begin
            if (sr_next[FW-1 -: 2] == 2'b10) begin
              state_d = ST_COMMIT;
              adr_d   = sr_next[DW +: AW];
              dat_d   = sr_next[DW-1:0];
            end else begin
              state_d = ST_WAIT;
            end
          end else if (cs_s) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else if (cs_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_COMMIT: begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (cs_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign bus_if.reg_wr  = (state_q == ST_COMMIT);
  assign bus_if.reg_adr = adr_q;
  assign bus_if.reg_dat = dat_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign frame_err_o    = err_q;
  assign frame_cnt_o    = frame_cnt_q;

`ifdef CFG_SPI_READBACK_EN
  logic          fall;
  logic [DW-1:0] sout_q, sout_d, rd_word;

  assign fall = ~sclk_s & sclk_dly_q;

  always_comb begin
    unique case (sr_next[1:0])
      2'd0:    rd_word = reg0_i;
      2'd1:    rd_word = reg1_i;
      2'd2:    rd_word = reg2_i;
      default: rd_word = reg3_i;
    endcase
  end

  // The fall right after the cmd byte is skipped so the host samples the MSB on the 9th rise.
  always_comb begin
    sout_d = sout_q;
    if (state_q == ST_IDLE) begin
      sout_d = '0;
    end else if (state_q == ST_SHIFT && rise && bit_cnt_q == CW'(7)
                 && sr_next[7:6] == 2'b11) begin
      sout_d = rd_word;
    end else if (fall && bit_cnt_q >= CW'(9)) begin
      sout_d = {sout_q[DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) sout_q <= '0;
    else        sout_q <= sout_d;
  end

  assign bus_if.spi_miso = ~cs_s & sout_q[DW-1];
`endif

endmodule

// File: tb/tb_cfg_spi_loader.sv
// Directed bench for cfg_spi_loader; covers the readback path when CFG_SPI_READBACK_EN is defined.
module tb_cfg_spi_loader;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 16;

  logic       clk;
  logic       rst_n;
  logic       busy, frame_err;
  logic [7:0] frame_cnt;
`ifdef CFG_SPI_READBACK_EN
  logic [DW-1:0] reg0, reg1, reg2, reg3;
  logic [DW-1:0] rd_val;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int hp    = 2;
  int wr_cycles  = 0;
  int err_cycles = 0;
  logic [AW+DW-1:0] wr_log[$];

  cfg_spi_loader_if #(.AW(AW), .DW(DW)) bus_if ();

  cfg_spi_loader #(.SYNC_STAGES(2), .AW(AW), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .bus_if      (bus_if),
`ifdef CFG_SPI_READBACK_EN
    .reg0_i      (reg0),
    .reg1_i      (reg1),
    .reg2_i      (reg2),
    .reg3_i      (reg3),
`endif
    .busy_o      (busy),
    .frame_err_o (frame_err),
    .frame_cnt_o (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_if.reg_wr === 1'b1) begin
      wr_cycles++;
      wr_log.push_back({bus_if.reg_adr, bus_if.reg_dat});
    end
    if (frame_err === 1'b1) err_cycles++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_frame(input logic [23:0] word, input int nbits,
                           input bit cs_at_last, input bit end_cs);
    bus_if.spi_cs_n = 1'b0;
    wait_clk(hp);
    for (int i = 0; i < nbits; i++) begin
      bus_if.spi_mosi = word[23-i];
      wait_clk(hp);
      bus_if.spi_sclk = 1'b1;
      if (cs_at_last && i == nbits - 1) bus_if.spi_cs_n = 1'b1;
      wait_clk(hp);
      bus_if.spi_sclk = 1'b0;
    end
    if (end_cs) begin
      wait_clk(hp);
      bus_if.spi_cs_n = 1'b1;
    end
  endtask

`ifdef CFG_SPI_READBACK_EN
  task automatic spi_read(input logic [7:0] cmd, output logic [15:0] rd);
    bus_if.spi_cs_n = 1'b0;
    wait_clk(hp);
    for (int i = 0; i < 24; i++) begin
      bus_if.spi_mosi = (i < 8) ? cmd[7-i] : 1'b0;
      wait_clk(hp);
      if (i >= 8) rd[23-i] = bus_if.spi_miso;
      bus_if.spi_sclk = 1'b1;
      wait_clk(hp);
      bus_if.spi_sclk = 1'b0;
    end
    wait_clk(hp);
    bus_if.spi_cs_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    bus_if.spi_sclk = 1'b0;
    bus_if.spi_cs_n = 1'b1;
    bus_if.spi_mosi = 1'b0;
`ifdef CFG_SPI_READBACK_EN
    reg0 = 16'h1111; reg1 = 16'h2222; reg2 = 16'hC0DE; reg3 = 16'h4444;
`endif
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);

    check("rst_wr",   32'(bus_if.reg_wr),  32'd0);
    check("rst_adr",  32'(bus_if.reg_adr), 32'd0);
    check("rst_dat",  32'(bus_if.reg_dat), 32'd0);
    check("rst_busy", 32'(busy),           32'd0);
    check("rst_err",  32'(frame_err),      32'd0);
    check("rst_cnt",  32'(frame_cnt),      32'd0);

    spi_frame(24'h81BEEF, 24, 1'b0, 1'b1);
    wait_clk(6);
    check("w1_n",     32'(wr_log.size()),  32'd1);
    check("w1_val",   32'(wr_log[0]),      32'h1BEEF);
    check("w1_width", 32'(wr_cycles),      32'd1);
    check("w1_cnt",   32'(frame_cnt),      32'd1);
    check("w1_err",   32'(err_cycles),     32'd0);
    check("w1_busy",  32'(busy),           32'd0);
    check("w1_hold",  {14'd0, bus_if.reg_adr, bus_if.reg_dat}, 32'h1BEEF);

    spi_frame(24'h831234, 24, 1'b0, 1'b1);
    wait_clk(1);
    spi_frame(24'h8000FF, 24, 1'b0, 1'b1);
    wait_clk(6);
    check("b2b_n",    32'(wr_log.size()),  32'd3);
    check("b2b_v0",   32'(wr_log[1]),      32'h31234);
    check("b2b_v1",   32'(wr_log[2]),      32'h000FF);
    check("b2b_cnt",  32'(frame_cnt),      32'd3);

    spi_frame(24'h82AAAA, 12, 1'b0, 1'b0);
    wait_clk(4);
    check("ab_busy1", 32'(busy),           32'd1);
    check("ab_err0",  32'(err_cycles),     32'd0);
    bus_if.spi_cs_n = 1'b1;
    wait_clk(6);
    check("ab_err",   32'(err_cycles),     32'd1);
    check("ab_nwr",   32'(wr_log.size()),  32'd3);
    check("ab_busy0", 32'(busy),           32'd0);

    spi_frame(24'h025555, 24, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      wait_clk(hp);
      bus_if.spi_sclk = 1'b1;
      wait_clk(hp);
      bus_if.spi_sclk = 1'b0;
    end
    wait_clk(4);
    check("nw_busy1", 32'(busy),           32'd1);
    bus_if.spi_cs_n = 1'b1;
    wait_clk(6);
    check("nw_busy0", 32'(busy),           32'd0);
    check("nw_nwr",   32'(wr_log.size()),  32'd3);
    check("nw_err",   32'(err_cycles),     32'd1);
    check("nw_cnt",   32'(frame_cnt),      32'd3);

    spi_frame(24'h813C3C, 24, 1'b1, 1'b0);
    wait_clk(8);
    check("csl_n",    32'(wr_log.size()),  32'd4);
    check("csl_val",  32'(wr_log[3]),      32'h13C3C);
    check("csl_err",  32'(err_cycles),     32'd1);
    check("csl_cnt",  32'(frame_cnt),      32'd4);

`ifdef CFG_SPI_READBACK_EN
    hp = 4;
    spi_read(8'hC2, rd_val);
    wait_clk(6);
    hp = 2;
    check("rd_data",  32'(rd_val),         32'hC0DE);
    check("rd_miso0", 32'(bus_if.spi_miso), 32'd0);
`else
    spi_frame(24'hC2C0DE, 24, 1'b0, 1'b1);
    wait_clk(6);
`endif
    check("rd_nwr",   32'(wr_log.size()),  32'd4);
    check("rd_err",   32'(err_cycles),     32'd1);
    check("rd_cnt",   32'(frame_cnt),      32'd4);

    for (int i = 0; i < 251; i++) begin
      spi_frame(24'h800000 | 24'(i), 24, 1'b0, 1'b1);
      wait_clk(4);
    end
    check("wr_cnt255", 32'(frame_cnt),     32'd255);
    spi_frame(24'h82ABCD, 24, 1'b0, 1'b1);
    wait_clk(6);
    check("wr_cnt0",  32'(frame_cnt),      32'd0);
    check("wr_n256",  32'(wr_log.size()),  32'd256);
    check("wr_last",  32'(wr_log[255]),    32'h2ABCD);

    spi_frame(24'h81FFFF, 20, 1'b0, 1'b0);
    rst_n = 1'b0;
    wait_clk(2);
    check("mr_busy",  32'(busy),           32'd0);
    check("mr_cnt",   32'(frame_cnt),      32'd0);
    bus_if.spi_cs_n = 1'b1;
    bus_if.spi_sclk = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(6);
    check("mr_nwr",   32'(wr_log.size()),  32'd256);
    check("mr_err",   32'(err_cycles),     32'd1);
    spi_frame(24'h837777, 24, 1'b0, 1'b1);
    wait_clk(6);
    check("pr_n",     32'(wr_log.size()),  32'd257);
    check("pr_val",   32'(wr_log[256]),    32'h37777);
    check("pr_cnt",   32'(frame_cnt),      32'd1);
    check("pr_width", 32'(wr_cycles),      32'd257);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
